// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the 32x32 register bank.
// Buffers writes in order, drains one per cycle, forwards pending data to readers.
module reg_wb_queue #(
   parameter int DEPTH      = 4,
   parameter bit ZERO_WIRED = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     WB_VALID,
   input  logic [4:0]               WB_ADDR,
   input  logic [31:0]              WB_DATA,
   output logic                     WB_READY,
   input  logic                     DRAIN_EN,
   output logic [4:0]               AW,
   output logic [31:0]              DIN,
   output logic                     REG_WRITE,
   input  logic [4:0]               AR1,
   input  logic [4:0]               AR2,
   input  logic [31:0]              BANK_DR1,
   input  logic [31:0]              BANK_DR2,
   output logic [31:0]              DR1,
   output logic [31:0]              DR2,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic not_empty;
   logic push_fire;
   logic store;
   logic pop;

   assign not_empty = (count_q != '0);
   assign WB_READY  = (count_q != CW'(DEPTH));
   assign push_fire = WB_VALID & WB_READY;
   // Writes to r0 complete the handshake but never occupy a slot
   assign store     = push_fire && !(ZERO_WIRED && (WB_ADDR == 5'd0));
   assign REG_WRITE = not_empty & DRAIN_EN;
   assign pop       = REG_WRITE;
   assign COUNT     = count_q;

   assign AW  = not_empty ? addr_q[head_q] : 5'd0;
   assign DIN = not_empty ? data_q[head_q] : 32'd0;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (store) begin
         tail_d = tail_q + PW'(1);
      end
      unique case ({store, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         addr_q[tail_q] <= WB_ADDR;
         data_q[tail_q] <= WB_DATA;
      end
   end

   // Walk oldest to newest so the youngest matching entry wins
   always_comb begin : fwd_blk
      logic [PW-1:0] idx;
      logic          live;
      DR1 = BANK_DR1;
      DR2 = BANK_DR2;
      idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx  = head_q + PW'(i);
         live = (CW'(i) < count_q);
         if (live && (addr_q[idx] == AR1) &&
             !(ZERO_WIRED && (AR1 == 5'd0))) begin
            DR1 = data_q[idx];
         end
         if (live && (addr_q[idx] == AR2) &&
             !(ZERO_WIRED && (AR2 == 5'd0))) begin
            DR2 = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: directed scenarios plus a random phase.
// A queue-based model predicts occupancy, drains and forwarded reads.
module tb_reg_wb_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        WB_VALID;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_DATA;
   logic        WB_READY;
   logic        DRAIN_EN;
   logic [4:0]  AW;
   logic [31:0] DIN;
   logic        REG_WRITE;
   logic [4:0]  AR1;
   logic [4:0]  AR2;
   logic [31:0] BANK_DR1;
   logic [31:0] BANK_DR2;
   logic [31:0] DR1;
   logic [31:0] DR2;
   logic [2:0]  COUNT;

   ent_t m_q[$];
   ent_t exp_q[$];
   int   acc_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   reg_wb_queue #(.DEPTH(DEPTH), .ZERO_WIRED(1'b1)) dut (
      .clk(clk), .rst(rst),
      .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
      .WB_READY(WB_READY), .DRAIN_EN(DRAIN_EN),
      .AW(AW), .DIN(DIN), .REG_WRITE(REG_WRITE),
      .AR1(AR1), .AR2(AR2),
      .BANK_DR1(BANK_DR1), .BANK_DR2(BANK_DR2),
      .DR1(DR1), .DR2(DR2), .COUNT(COUNT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] ar,
                                       input logic [31:0] bank);
      logic [31:0] r;
      r = bank;
      if (ar != 5'd0) begin
         foreach (m_q[i]) begin
            if (m_q[i].a == ar) r = m_q[i].d;
         end
      end
      return r;
   endfunction

   // Reference model: queue contents after each edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         exp_q.delete();
      end else begin
         bit   do_pop;
         bit   do_push;
         ent_t e;
         do_pop  = (m_q.size() > 0) && DRAIN_EN;
         do_push = WB_VALID && (m_q.size() < DEPTH);
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            acc_cnt++;
            if (WB_ADDR != 5'd0) begin
               e.a = WB_ADDR;
               e.d = WB_DATA;
               m_q.push_back(e);
               exp_q.push_back(e);
            end
         end
      end
   end

   // Monitor: compare DUT outputs mid-cycle
   always @(negedge clk) begin
      ent_t e;
      chk("ready", 32'(WB_READY), 32'(m_q.size() < DEPTH));
      chk("count", 32'(COUNT), 32'(m_q.size()));
      chk("reg_write", 32'(REG_WRITE), 32'((m_q.size() > 0) && DRAIN_EN));
      if (REG_WRITE === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("drain_unexpected", 32'(REG_WRITE), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("drain_aw", 32'(AW), 32'(e.a));
            chk("drain_din", DIN, e.d);
         end
      end else if (m_q.size() == 0) begin
         chk("empty_aw", 32'(AW), 32'd0);
         chk("empty_din", DIN, 32'd0);
      end else begin
         chk("head_aw", 32'(AW), 32'(m_q[0].a));
         chk("head_din", DIN, m_q[0].d);
      end
      chk("dr1", DR1, fwd(AR1, BANK_DR1));
      chk("dr2", DR2, fwd(AR2, BANK_DR2));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      int n0;
      WB_VALID = 1'b1;
      WB_ADDR  = a;
      WB_DATA  = d;
      n0 = acc_cnt;
      for (int k = 0; k < 20 && acc_cnt == n0; k++) tick();
      if (acc_cnt == n0) chk("push_timeout", 32'(acc_cnt), 32'(n0 + 1));
      WB_VALID = 1'b0;
   endtask

   task automatic wait_empty();
      for (int k = 0; k < 20 && m_q.size() != 0; k++) tick();
      chk("drain_done", 32'(COUNT), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1);
   end

   initial begin
      int n0;
      rst = 1'b1;
      WB_VALID = 1'b0;
      WB_ADDR = '0;
      WB_DATA = '0;
      DRAIN_EN = 1'b0;
      AR1 = '0;
      AR2 = '0;
      BANK_DR1 = 32'h0;
      BANK_DR2 = 32'h0;
      repeat (2) tick();
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_ready", 32'(WB_READY), 32'd1);
      rst = 1'b0;
      tick();

      // Single write drains the cycle after acceptance
      DRAIN_EN = 1'b1;
      push(5'd5, 32'hDEADBEEF);
      chk("t1_rw", 32'(REG_WRITE), 32'd1);
      chk("t1_aw", 32'(AW), 32'd5);
      chk("t1_din", DIN, 32'hDEADBEEF);
      tick();
      chk("t1_rw_off", 32'(REG_WRITE), 32'd0);
      chk("t1_count", 32'(COUNT), 32'd0);

      // Fill, hold a fifth request, then drain in order
      DRAIN_EN = 1'b0;
      for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
      chk("t2_count", 32'(COUNT), 32'd4);
      chk("t2_full", 32'(WB_READY), 32'd0);
      WB_VALID = 1'b1;
      WB_ADDR  = 5'd6;
      WB_DATA  = 32'h55;
      n0 = acc_cnt;
      repeat (3) tick();
      chk("t2_held", 32'(acc_cnt - n0), 32'd0);
      DRAIN_EN = 1'b1;
      tick();
      chk("t2_ready_up", 32'(WB_READY), 32'd1);
      chk("t2_aw_next", 32'(AW), 32'd2);
      for (int k = 0; k < 5 && acc_cnt == n0; k++) tick();
      WB_VALID = 1'b0;
      chk("t2_fifth", 32'(acc_cnt - n0), 32'd1);
      wait_empty();

      // Newest pending entry wins forwarding
      DRAIN_EN = 1'b0;
      AR1 = 5'd7;
      BANK_DR1 = 32'h0;
      push(5'd7, 32'hA);
      push(5'd7, 32'hB);
      chk("t3_fwd", DR1, 32'hB);
      DRAIN_EN = 1'b1;
      tick();
      DRAIN_EN = 1'b0;
      BANK_DR1 = 32'h55;
      #1;
      chk("t3_fwd_one", DR1, 32'hB);
      DRAIN_EN = 1'b1;
      tick();
      chk("t3_bank", DR1, 32'h55);

      // Writes to r0 are swallowed
      push(5'd0, 32'h1234);
      chk("t4_count", 32'(COUNT), 32'd0);
      chk("t4_rw", 32'(REG_WRITE), 32'd0);
      AR2 = 5'd0;
      BANK_DR2 = 32'h0;
      #1;
      chk("t4_dr2", DR2, 32'h0);

      // Steady push+pop at occupancy 2 across pointer wrap
      DRAIN_EN = 1'b0;
      push(5'd20, 32'h100);
      push(5'd21, 32'h101);
      DRAIN_EN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(5'(1 + i), 32'h200 + 32'(i));
         chk("t5_count", 32'(COUNT), 32'd2);
      end
      wait_empty();

      // Asynchronous reset between edges
      DRAIN_EN = 1'b0;
      push(5'd10, 32'hA0);
      push(5'd11, 32'hA1);
      push(5'd12, 32'hA2);
      chk("t6_count3", 32'(COUNT), 32'd3);
      DRAIN_EN = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rw", 32'(REG_WRITE), 32'd0);
      chk("t6_count", 32'(COUNT), 32'd0);
      chk("t6_aw", 32'(AW), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         AR1 = 5'(a);
         AR2 = 5'(31 - a);
         BANK_DR1 = $urandom;
         BANK_DR2 = $urandom;
         #1;
         chk("t6_dr1", DR1, BANK_DR1);
         chk("t6_dr2", DR2, BANK_DR2);
      end

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         if (!WB_VALID && $urandom_range(0, 2) != 0) begin
            WB_VALID = 1'b1;
            WB_ADDR  = 5'($urandom_range(0, 7));
            WB_DATA  = $urandom;
         end
         DRAIN_EN = ($urandom_range(0, 1) != 0);
         AR1 = 5'($urandom_range(0, 7));
         AR2 = 5'($urandom_range(0, 7));
         BANK_DR1 = $urandom;
         BANK_DR2 = $urandom;
         n0 = acc_cnt;
         tick();
         if (acc_cnt != n0) WB_VALID = 1'b0;
      end
      WB_VALID = 1'b0;
      DRAIN_EN = 1'b1;
      wait_empty();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
